// File: rtl/uve_wb_arbiter.sv
// UVE writeback stage: round-robin arbitration of functional-unit results onto one registered
// register-file write port (vector or predicate), plus the busy-bitmap scoreboard for issue.
module uve_wb_arbiter #(
  parameter int NR_SRC          = 3,
  parameter int VEC_DATA_WIDTH  = 128,
  parameter int PRED_DATA_WIDTH = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NR_SRC-1:0]                    src_valid_i,
  output logic [NR_SRC-1:0]                    src_ready_o,
  input  logic [NR_SRC-1:0]                    src_is_pred_i,
  input  logic [NR_SRC-1:0][4:0]               src_addr_i,
  input  logic [NR_SRC-1:0][VEC_DATA_WIDTH-1:0] src_data_i,
  output logic                                 v_we_o,
  output logic [4:0]                           v_waddr_o,
  output logic [VEC_DATA_WIDTH-1:0]            v_wdata_o,
  output logic                                 p_we_o,
  output logic [3:0]                           p_waddr_o,
  output logic [PRED_DATA_WIDTH-1:0]           p_wdata_o,
  input  logic                                 iss_valid_i,
  input  logic                                 iss_is_pred_i,
  input  logic [4:0]                           iss_addr_i,
  output logic                                 iss_ready_o,
  output logic [31:0]                          v_busy_o,
  output logic [15:0]                          p_busy_o
);

  localparam int PTR_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

  logic [PTR_W-1:0] rr_ptr_q;
  logic             grant_valid;
  logic [PTR_W-1:0] grant_idx;

  // Scan from the round-robin pointer upward with wrap; the first valid source wins.
  always_comb begin
    int cand;
    logic [PTR_W-1:0] cand_idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned
    // (which would infer a latch); blocking '=' is correct here, '<=' belongs in always_ff only.
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 0; i < NR_SRC; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NR_SRC) cand = cand - NR_SRC;
      cand_idx = PTR_W'(cand);
      if (!grant_valid && src_valid_i[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    if (flush_i) grant_valid = 1'b0;
  end

  assign src_ready_o = grant_valid ? (NR_SRC'(1) << grant_idx) : '0;

  logic                      g_pred;
  logic [4:0]                g_addr;
  logic [VEC_DATA_WIDTH-1:0] g_data;
  logic                      g_pred_live;

  assign g_pred      = src_is_pred_i[grant_idx];
  assign g_addr      = src_addr_i[grant_idx];
  assign g_data      = src_data_i[grant_idx];
  // A predicate result aimed at p0 is accepted but never written.
  assign g_pred_live = g_pred && (g_addr[3:0] != 4'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (grant_valid) begin
      rr_ptr_q <= (grant_idx == PTR_W'(NR_SRC - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Address/data only move when their own port is written; otherwise they hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_we_o    <= 1'b0;
      v_waddr_o <= '0;
      v_wdata_o <= '0;
      p_we_o    <= 1'b0;
      p_waddr_o <= '0;
      p_wdata_o <= '0;
    end else begin
      v_we_o <= grant_valid && !g_pred;
      p_we_o <= grant_valid && g_pred_live;
      if (grant_valid && !g_pred) begin
        v_waddr_o <= g_addr;
        v_wdata_o <= g_data;
      end
      if (grant_valid && g_pred_live) begin
        p_waddr_o <= g_addr[3:0];
        p_wdata_o <= g_data[PRED_DATA_WIDTH-1:0];
      end
    end
  end

  logic [31:0] v_busy_q, v_busy_d;
  logic [15:0] p_busy_q, p_busy_d;
  logic        iss_p0;
  logic        iss_set;

  assign iss_p0      = iss_is_pred_i && (iss_addr_i[3:0] == 4'd0);
  assign iss_ready_o = iss_is_pred_i ? (iss_p0 || !p_busy_q[iss_addr_i[3:0]])
                                     : !v_busy_q[iss_addr_i];
  assign iss_set     = iss_valid_i && iss_ready_o && !iss_p0 && !flush_i;

  // Clear on the landing write first, then apply the issue so a same-cycle set wins.
  always_comb begin
    v_busy_d = v_busy_q;
    p_busy_d = p_busy_q;
    if (v_we_o) v_busy_d[v_waddr_o] = 1'b0;
    if (p_we_o) p_busy_d[p_waddr_o] = 1'b0;
    if (iss_set) begin
      if (iss_is_pred_i) p_busy_d[iss_addr_i[3:0]] = 1'b1;
      else               v_busy_d[iss_addr_i]      = 1'b1;
    end
    if (flush_i) begin
      v_busy_d = '0;
      p_busy_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_busy_q <= '0;
      p_busy_q <= '0;
    end else begin
      v_busy_q <= v_busy_d;
      p_busy_q <= p_busy_d;
    end
  end

  assign v_busy_o = v_busy_q;
  assign p_busy_o = p_busy_q;

endmodule

// File: tb/tb_uve_wb_arbiter.sv
// Self-checking bench for uve_wb_arbiter: vector table, directed corner sequences and
// randomized traffic against a behavioural model of the arbitration and scoreboard rules.
module tb_uve_wb_arbiter;

  localparam int N  = 3;
  localparam int VW = 128;
  localparam int PW = 64;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  flush_i;
  logic [N-1:0]          src_valid_i, src_ready_o, src_is_pred_i;
  logic [N-1:0][4:0]     src_addr_i;
  logic [N-1:0][VW-1:0]  src_data_i;
  logic                  v_we_o, p_we_o;
  logic [4:0]            v_waddr_o;
  logic [VW-1:0]         v_wdata_o;
  logic [3:0]            p_waddr_o;
  logic [PW-1:0]         p_wdata_o;
  logic                  iss_valid_i, iss_is_pred_i, iss_ready_o;
  logic [4:0]            iss_addr_i;
  logic [31:0]           v_busy_o;
  logic [15:0]           p_busy_o;

  uve_wb_arbiter #(.NR_SRC(N), .VEC_DATA_WIDTH(VW), .PRED_DATA_WIDTH(PW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .src_is_pred_i(src_is_pred_i),
    .src_addr_i(src_addr_i), .src_data_i(src_data_i),
    .v_we_o(v_we_o), .v_waddr_o(v_waddr_o), .v_wdata_o(v_wdata_o),
    .p_we_o(p_we_o), .p_waddr_o(p_waddr_o), .p_wdata_o(p_wdata_o),
    .iss_valid_i(iss_valid_i), .iss_is_pred_i(iss_is_pred_i), .iss_addr_i(iss_addr_i),
    .iss_ready_o(iss_ready_o), .v_busy_o(v_busy_o), .p_busy_o(p_busy_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: pointer as an integer, busy sets as bit vectors, pending write as fields.
  int             m_rr;
  bit [31:0]      m_vbusy;
  bit [15:0]      m_pbusy;
  bit             m_vwe, m_pwe;
  bit [4:0]       m_vaddr;
  bit [3:0]       m_paddr;
  logic [VW-1:0]  m_vdata;
  logic [PW-1:0]  m_pdata;
  logic [N-1:0]   seen_ready;
  logic           seen_iss_ready;

  function automatic void m_reset();
    m_rr = 0; m_vbusy = '0; m_pbusy = '0; m_vwe = 1'b0; m_pwe = 1'b0;
    m_vaddr = '0; m_paddr = '0; m_vdata = '0; m_pdata = '0;
  endfunction

  function automatic int model_grant();
    if (flush_i) return -1;
    for (int i = 0; i < N; i++) begin
      int k = (m_rr + i) % N;
      if (src_valid_i[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit model_iss_ready();
    if (iss_is_pred_i) return (iss_addr_i[3:0] == 4'd0) ? 1'b1 : !m_pbusy[iss_addr_i[3:0]];
    return !m_vbusy[iss_addr_i];
  endfunction

  // Called just after a rising edge with inputs already applied; ends just after the next edge.
  task automatic cycle();
    int g;
    bit ir;
    logic [N-1:0] exp_rdy;
    #3;
    g  = model_grant();
    ir = model_iss_ready();
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    seen_ready     = src_ready_o;
    seen_iss_ready = iss_ready_o;
    check("src_ready", src_ready_o, exp_rdy);
    check("iss_ready", iss_ready_o, ir);
    if (flush_i) begin
      m_vbusy = '0; m_pbusy = '0; m_vwe = 1'b0; m_pwe = 1'b0;
    end else begin
      if (m_vwe) m_vbusy[m_vaddr] = 1'b0;
      if (m_pwe) m_pbusy[m_paddr] = 1'b0;
      if (iss_valid_i && ir && !(iss_is_pred_i && iss_addr_i[3:0] == 4'd0)) begin
        if (iss_is_pred_i) m_pbusy[iss_addr_i[3:0]] = 1'b1;
        else               m_vbusy[iss_addr_i]      = 1'b1;
      end
      m_vwe = 1'b0; m_pwe = 1'b0;
      if (g >= 0) begin
        m_rr = (g + 1) % N;
        if (!src_is_pred_i[g]) begin
          m_vwe = 1'b1; m_vaddr = src_addr_i[g]; m_vdata = src_data_i[g];
        end else if (src_addr_i[g][3:0] != 4'd0) begin
          m_pwe = 1'b1; m_paddr = src_addr_i[g][3:0]; m_pdata = src_data_i[g][PW-1:0];
        end
      end
    end
    @(posedge clk_i);
    #1;
    check("v_we", v_we_o, m_vwe);
    check("p_we", p_we_o, m_pwe);
    if (m_vwe) begin
      check("v_waddr", v_waddr_o, m_vaddr);
      check("v_wdata", v_wdata_o, m_vdata);
    end
    if (m_pwe) begin
      check("p_waddr", p_waddr_o, m_paddr);
      check("p_wdata", p_wdata_o, m_pdata);
    end
    check("v_busy", v_busy_o, m_vbusy);
    check("p_busy", p_busy_o, m_pbusy);
  endtask

  task automatic idle();
    flush_i = 1'b0; src_valid_i = '0; iss_valid_i = 1'b0;
  endtask

  task automatic drive_src(input int k, input bit pred, input logic [4:0] addr,
                           input logic [VW-1:0] data);
    src_valid_i[k] = 1'b1; src_is_pred_i[k] = pred; src_addr_i[k] = addr; src_data_i[k] = data;
  endtask

  task automatic drive_iss(input bit pred, input logic [4:0] addr);
    iss_valid_i = 1'b1; iss_is_pred_i = pred; iss_addr_i = addr;
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] exp_ready;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{3'b111, 3'b001};
    tbl[1] = '{3'b111, 3'b010};
    tbl[2] = '{3'b111, 3'b100};
    tbl[3] = '{3'b101, 3'b001};
    tbl[4] = '{3'b101, 3'b100};
    tbl[5] = '{3'b101, 3'b001};
    tbl[6] = '{3'b110, 3'b010};
    tbl[7] = '{3'b010, 3'b010};
    tbl[8] = '{3'b000, 3'b000};
    tbl[9] = '{3'b011, 3'b001};

    rst_ni = 1'b0; idle();
    src_is_pred_i = '0; src_addr_i = '0; src_data_i = '0;
    iss_is_pred_i = 1'b0; iss_addr_i = '0;
    m_reset();
    #2;
    check("rst_v_we", v_we_o, 1'b0);
    check("rst_p_we", p_we_o, 1'b0);
    check("rst_v_busy", v_busy_o, 32'h0);
    check("rst_p_busy", p_busy_o, 16'h0);
    check("rst_ready", src_ready_o, 3'b000);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Round-robin table from a fresh pointer, all vector results.
    for (int k = 0; k < N; k++) drive_src(k, 1'b0, 5'(k + 1), {4{32'(k + 32'h100)}});
    for (int i = 0; i < 10; i++) begin
      src_valid_i = tbl[i].valid;
      cycle();
      check($sformatf("tbl_ready_%0d", i), seen_ready, tbl[i].exp_ready);
    end

    // Issue vreg5, then its result lands and releases it.
    idle(); drive_iss(1'b0, 5'd5); cycle();
    check("a_iss_ready", seen_iss_ready, 1'b1);
    check("a_busy5_set", v_busy_o[5], 1'b1);
    idle(); drive_src(0, 1'b0, 5'd5, {4{32'hA5A5_A5A5}}); cycle();
    check("a_ready0", seen_ready, 3'b001);
    check("a_vwe", v_we_o, 1'b1);
    check("a_waddr", v_waddr_o, 5'd5);
    check("a_busy5_hold", v_busy_o[5], 1'b1);
    idle(); cycle();
    check("a_busy5_clr", v_busy_o[5], 1'b0);

    // Back-to-back issue of vreg7, then issue in the write cycle: set beats clear.
    idle(); drive_iss(1'b0, 5'd7); cycle();
    cycle();
    check("b_iss_ready2", seen_iss_ready, 1'b0);
    idle(); drive_src(0, 1'b0, 5'd7, {4{32'h0707_0707}}); cycle();
    idle(); cycle();
    check("b_busy7_clr", v_busy_o[7], 1'b0);
    drive_src(0, 1'b0, 5'd7, {4{32'h7777_0000}}); cycle();
    idle(); drive_iss(1'b0, 5'd7); cycle();
    check("b_iss_ready_wr", seen_iss_ready, 1'b1);
    check("b_set_wins", v_busy_o[7], 1'b1);

    // Predicate p0 (addr bit 4 set, ignored) and predicate p3.
    idle(); drive_src(1, 1'b1, 5'b10000, {4{32'h1234_5678}}); drive_iss(1'b1, 5'b10000); cycle();
    check("c_p0_ready", seen_ready, 3'b010);
    check("c_p0_iss_ready", seen_iss_ready, 1'b1);
    check("c_p0_pwe", p_we_o, 1'b0);
    check("c_p0_pbusy", p_busy_o, 16'h0);
    idle(); drive_iss(1'b1, 5'd3); cycle();
    check("c_p3_busy", p_busy_o[3], 1'b1);
    idle(); drive_src(2, 1'b1, 5'd3, {64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_0001}); cycle();
    check("c_p3_ready", seen_ready, 3'b100);
    check("c_p3_pwe", p_we_o, 1'b1);
    check("c_p3_waddr", p_waddr_o, 4'd3);
    check("c_p3_wdata", p_wdata_o, 64'hFFFF_FFFF_FFFF_0001);
    idle(); cycle();
    check("c_p3_clr", p_busy_o[3], 1'b0);

    // Flush with a grant pending and v_busy = 0xF0 (bit 7 still held from above).
    for (int a = 4; a < 7; a++) begin
      idle(); drive_iss(1'b0, 5'(a)); cycle();
    end
    check("d_busy_f0", v_busy_o, 32'hF0);
    idle(); drive_src(0, 1'b0, 5'd9, {4{32'h0909_0909}}); cycle();
    flush_i = 1'b1; drive_iss(1'b0, 5'd9); cycle();
    check("d_flush_ready", seen_ready, 3'b000);
    check("d_flush_vwe", v_we_o, 1'b0);
    check("d_flush_busy", v_busy_o, 32'h0);
    idle(); src_valid_i = 3'b111; cycle();
    check("d_rr_held", seen_ready, 3'b010);

    // Random traffic with a reset in the middle.
    for (int r = 0; r < 400; r++) begin
      if (r == 200) begin
        for (int k = 0; k < N; k++) drive_src(k, 1'b0, 5'(k + 10), {4{$urandom}});
        rst_ni = 1'b0;
        #1;
        check("e_rst_vwe", v_we_o, 1'b0);
        check("e_rst_pwe", p_we_o, 1'b0);
        check("e_rst_vbusy", v_busy_o, 32'h0);
        check("e_rst_pbusy", p_busy_o, 16'h0);
        m_reset();
        #1;
        rst_ni = 1'b1;
        flush_i = 1'b0; iss_valid_i = 1'b0;
        cycle();
        check("e_rst_restart", seen_ready, 3'b001);
      end else begin
        flush_i       = ($urandom_range(0, 19) == 0);
        src_valid_i   = N'($urandom);
        src_is_pred_i = N'($urandom);
        for (int k = 0; k < N; k++) begin
          src_addr_i[k] = 5'($urandom);
          src_data_i[k] = {$urandom, $urandom, $urandom, $urandom};
        end
        iss_valid_i   = 1'($urandom);
        iss_is_pred_i = 1'($urandom);
        iss_addr_i    = 5'($urandom);
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
